icache_controller: RTL and testbench
====================================

Name: icache_controller

Overview:
- Direct-mapped instruction cache and controller placed between the CPU fetch stage and the 16-byte-block instruction memory.
- Serves 32-bit instruction words to the CPU on hits with zero wait cycles.
- On a miss, stalls the CPU, sequences a block read from instruction memory using its read/busywait handshake, then installs the line.
- Keeps saturating hit and miss counters for performance profiling.

Parameters:
- NUM_LINES, 8, cache lines (fixed for 10-bit address split below; other values unsupported)
- CNT_WIDTH, 16, width of hit/miss counters

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset_n  in  1  asynchronous active-low reset
- address  in  10  CPU byte address (PC); [9:7] tag, [6:4] index, [3:2] word offset, [1:0] ignored
- read  in  1  CPU fetch request
- flush  in  1  invalidate-all request, sampled on posedge
- instruction  out  32  fetched instruction word
- busywait  out  1  CPU stall
- mem_read  out  1  instruction memory read request
- mem_address  out  6  block address to instruction memory ({tag,index})
- mem_readinst  in  128  block data from memory; byte k of block at bits [8k+7:8k]
- mem_busywait  in  1  instruction memory busy
- hit_count  out  CNT_WIDTH  saturating hit counter
- miss_count  out  CNT_WIDTH  saturating miss counter

Behaviour:
- Storage: per line valid bit, 3-bit tag, 128-bit data. hit = valid[index] && tag[index]==address[9:7].
- Word select: instruction = data[index][32*offset+31 : 32*offset]. Combinational from address.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - busywait = read && !hit (combinational).
  - mem_read = 0.
  - On posedge with read && !hit, go to MEM_READ.
- MEM_READ:
  - busywait = 1, mem_read = 1, mem_address = {address[9:7], address[6:4]}.
  - A seen_busy flag sets on any posedge with mem_busywait = 1.
  - Exit to UPDATE on the first posedge with seen_busy = 1 and mem_busywait = 0.
  - seen_busy clears on exit.
- UPDATE:
  - busywait = 1, mem_read = 0.
  - On posedge: data[index] <= mem_readinst, tag[index] <= address[9:7], valid[index] <= 1; go to IDLE.
  - The next IDLE cycle then hits and releases busywait.
- address is required stable while busywait = 1; the controller does not latch it.
- read = 0 in IDLE: busywait = 0; instruction is still driven from the indexed line (don't-care to CPU).
- Flush:
  - Sampled in IDLE: all valid bits clear on that posedge. A coincident read is evaluated against pre-flush state for busywait that cycle; no fill starts that edge.
  - Asserted in MEM_READ or UPDATE: latched as pending and applied on the posedge that returns to IDLE. The just-filled line is also invalidated.
- Counters:
  - hit_count increments on each posedge in IDLE with read && hit && !flush.
  - miss_count increments on each IDLE->MEM_READ transition.
  - Both saturate at all-ones. The hit after a fill counts as a hit, so a cold miss yields miss +1 and hit +1.
- Reset (reset_n low, any time, including mid-fill):
  - state = IDLE; all valid = 0; seen_busy and flush-pending = 0; counters = 0.
  - mem_read = 0 immediately; busywait = 0 while read = 0.
  - Tag/data arrays are not reset.
  - A memory transfer already in progress is ignored; no line is written.
- Memory handshake: mem_read is held high until memory completes. The controller never deasserts it early except on reset.

Test Plan:
- Cold miss, with block 0x02 preloaded with words W0..W3, read=1, address=0x024:
  - busywait rises the same cycle; mem_read=1 with mem_address=0x02 until mem_busywait falls.
  - UPDATE follows, then instruction=W1 with busywait=0.
  - Counters end at miss_count=1, hit_count=1.
- Sequential hits at 0x020, 0x028, 0x02C after the fill: instruction = W0, W2, W3 each cycle; busywait stays 0; no mem_read.
- Conflict eviction: fetch 0x0A4 (index 2, tag 1) after 0x024 -> miss, mem_address=0x0A; refetch 0x024 -> miss again; miss_count += 2.
- Flush in IDLE:
  - Assert flush one cycle after lines are filled, then read 0x024 -> miss.
  - Flush asserted mid-MEM_READ -> line still filled, then invalidated on return to IDLE; the next fetch misses.
- Reset mid-fill: pull reset_n low during MEM_READ -> mem_read drops immediately, counters read 0; after release, 0x024 misses and refetches correctly.
- Saturation, with CNT_WIDTH=4: 20 consecutive hits -> hit_count holds at 15.

Source files
------------

// File: rtl/icache_controller.sv
// Direct-mapped 8-line instruction cache with a blocking miss FSM that fills
// 16-byte blocks from instruction memory, plus saturating hit/miss counters.
module icache_controller #(
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [9:0]           address,
    input  logic                 read,
    input  logic                 flush,
    output logic [31:0]          instruction,
    output logic                 busywait,
    output logic                 mem_read,
    output logic [5:0]           mem_address,
    input  logic [127:0]         mem_readinst,
    input  logic                 mem_busywait,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_e;

    state_e               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic                 seen_busy_q, seen_busy_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    logic [2:0]   tag_q  [NUM_LINES];
    logic [127:0] data_q [NUM_LINES];

    logic [2:0] addr_tag;
    logic [2:0] addr_idx;
    logic [1:0] addr_off;
    logic       hit;
    logic       fill_we;
    logic       unused_addr_bits;

    assign addr_tag         = address[9:7];
    assign addr_idx         = address[6:4];
    assign addr_off         = address[3:2];
    assign unused_addr_bits = ^address[1:0];

    assign hit         = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    assign instruction = data_q[addr_idx][{addr_off, 5'b0} +: 32];
    assign mem_address = {addr_tag, addr_idx};
    assign fill_we     = (state_q == UPDATE);
    assign hit_count   = hit_cnt_q;
    assign miss_count  = miss_cnt_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        seen_busy_d  = seen_busy_q;
        flush_pend_d = flush_pend_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        busywait     = 1'b0;
        mem_read     = 1'b0;

        unique case (state_q)
            IDLE: begin
                busywait = read && !hit;
                // Flush wins over a coincident miss: no fill starts, nothing counted.
                if (flush) begin
                    valid_d = '0;
                end else if (read && !hit) begin
                    state_d = MEM_READ;
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                end else if (read) begin
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                end
            end
            MEM_READ: begin
                busywait = 1'b1;
                mem_read = 1'b1;
                if (flush) flush_pend_d = 1'b1;
                if (mem_busywait) seen_busy_d = 1'b1;
                if (seen_busy_q && !mem_busywait) begin
                    state_d     = UPDATE;
                    seen_busy_d = 1'b0;
                end
            end
            UPDATE: begin
                busywait = 1'b1;
                state_d  = IDLE;
                valid_d[addr_idx] = 1'b1;
                // A flush seen during the fill also drops the line just written.
                if (flush_pend_q || flush) valid_d = '0;
                flush_pend_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            seen_busy_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            seen_busy_q  <= seen_busy_d;
            flush_pend_q <= flush_pend_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (fill_we) begin
            data_q[addr_idx] <= mem_readinst;
            tag_q[addr_idx]  <= addr_tag;
        end
    end

endmodule

// File: tb/tb_icache_controller.sv
// Scoreboarded bench for icache_controller: behavioural cache model plus a
// randomised handshaking instruction memory.
module tb_icache_controller;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [9:0]    address;
    logic          read;
    logic          flush;
    logic [31:0]   instruction;
    logic          busywait;
    logic          mem_read;
    logic [5:0]    mem_address;
    logic [127:0]  mem_readinst;
    logic          mem_busywait;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    icache_controller #(.NUM_LINES(8), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .flush(flush), .instruction(instruction), .busywait(busywait),
        .mem_read(mem_read), .mem_address(mem_address),
        .mem_readinst(mem_readinst), .mem_busywait(mem_busywait),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] word;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] mem [64];
    int           total = 0;
    int           bad   = 0;

    // reference model state
    bit         m_valid [8];
    logic [2:0] m_tag   [8];
    int         m_hits  = 0;
    int         m_miss  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        logic [127:0] blk;
        blk = mem[a[9:4]];
        return blk[32*a[3:2] +: 32];
    endfunction

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_hits"}, 32'(hit_count), 32'(m_hits));
        chk({tag, "_miss"}, 32'(miss_count), 32'(m_miss));
    endtask

    // memory: busy for a random number of cycles, then presents the block
    initial begin
        int phase = 0;
        int cnt   = 0;
        mem_busywait = 1'b0;
        mem_readinst = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                phase = 0;
                mem_busywait = 1'b0;
            end else if (phase == 0) begin
                if (mem_read) begin
                    mem_busywait = 1'b1;
                    mem_readinst = {$urandom, $urandom, $urandom, $urandom};
                    cnt   = $urandom_range(1, 4);
                    phase = 1;
                end
            end else if (phase == 1) begin
                cnt--;
                if (cnt == 0) begin
                    mem_busywait = 1'b0;
                    mem_readinst = mem[mem_address];
                    phase = 2;
                end
            end else if (!mem_read) begin
                phase = 0;
            end
        end
    end

    // monitor: pops an expectation whenever a fetch is being served
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n && mem_read && exp_q.size() > 0)
                chk("mem_address", 32'(mem_address), 32'(exp_q[0].addr[9:4]));
            if (reset_n && read && !busywait) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_fetch", 32'(address), 32'h3ff_ffff);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("fetch_addr", 32'(address), 32'(e.addr));
                    chk("instruction", instruction, e.word);
                end
            end
        end
    end

    task automatic fetch(input logic [9:0] a, input bit flush_mid);
        bit   exp_miss;
        bit   waited;
        bit   flush_done;
        int   n;
        exp_t e;
        exp_miss = !(m_valid[a[6:4]] && m_tag[a[6:4]] == a[9:7]);
        if (exp_miss) begin
            m_miss = sat(m_miss);
            if (flush_mid) m_miss = sat(m_miss);
            m_valid[a[6:4]] = 1'b1;
            m_tag[a[6:4]]   = a[9:7];
        end
        m_hits = sat(m_hits);
        e.addr = a;
        e.word = mem_word(a);
        exp_q.push_back(e);
        address    = a;
        read       = 1'b1;
        waited     = 1'b0;
        flush_done = 1'b0;
        n          = 0;
        forever begin
            @(negedge clock);
            if (!busywait) break;
            waited = 1'b1;
            n++;
            if (n > 100) begin
                chk("fetch_timeout", 32'(n), 32'd100);
                exp_q.delete();
                read = 1'b0;
                return;
            end
            if (flush_mid && !flush_done && mem_read) begin
                flush = 1'b1;
                @(posedge clock);
                #1 flush = 1'b0;
                flush_done = 1'b1;
            end else begin
                @(posedge clock);
                #1;
            end
        end
        @(posedge clock);
        #1 read = 1'b0;
        chk("stall", 32'(waited), 32'(exp_miss));
    endtask

    task automatic idle_flush();
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        read    = 1'b0;
        flush   = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int n;
        address = '0;
        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        do_reset();
        check_counters("reset");
        chk("reset_busywait", 32'(busywait), 32'd0);
        chk("reset_mem_read", 32'(mem_read), 32'd0);

        // cold miss, sequential hits, conflict eviction
        fetch(10'h024, 1'b0);
        check_counters("cold");
        fetch(10'h020, 1'b0);
        fetch(10'h028, 1'b0);
        fetch(10'h02C, 1'b0);
        fetch(10'h0A4, 1'b0);
        fetch(10'h024, 1'b0);
        check_counters("conflict");

        // flush in idle, then flush during a fill
        idle_flush();
        fetch(10'h024, 1'b0);
        fetch(10'h0A4, 1'b1);
        fetch(10'h0A8, 1'b0);
        check_counters("flush");

        // reset while the controller is mid-fill
        idle_flush();
        address = 10'h024;
        read    = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!mem_read && n < 20);
        chk("reach_mem_read", 32'(mem_read), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_hits", 32'(hit_count), 32'd0);
        chk("rst_miss", 32'(miss_count), 32'd0);
        read = 1'b0;
        #1;
        chk("rst_busywait", 32'(busywait), 32'd0);
        model_reset();
        @(posedge clock);
        #1 reset_n = 1'b1;
        fetch(10'h024, 1'b0);
        check_counters("after_reset");

        // randomised traffic over two tags to mix hits and conflicts
        do_reset();
        for (int i = 0; i < 250; i++) begin
            int r;
            logic [9:0] a;
            r = $urandom_range(0, 29);
            a = {2'b00, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if (r == 0) idle_flush();
            else if (r == 1) begin
                @(posedge clock);
                #1;
            end else fetch(a, r == 2);
            if (i % 25 == 0) check_counters("random");
        end
        check_counters("random_end");

        // hit counter saturation
        do_reset();
        fetch(10'h024, 1'b0);
        for (int i = 0; i < 20; i++) fetch(10'h028, 1'b0);
        chk("sat_hits", 32'(hit_count), 32'd15);
        chk("sat_miss", 32'(miss_count), 32'd1);

        repeat (2) @(posedge clock);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
